lambda_seq_ctrl: RTL

//  Sequences one latent frame of N_ELEM (mean, var) pairs through the single shared lambda
//  (reparameterisation) pipeline: lambda = mean + sqrt(softplus(var)) * eps.

---
 rtl/lambda_seq_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lambda_seq_ctrl.sv
// lambda_seq_ctrl
//   Feeds one latent frame of N_ELEM (mean, var) pairs through the shared lambda
//   (reparameterisation) pipeline, lambda = mean + sqrt(softplus(var)) * eps.
//   It accepts at most one pair per cycle and tags each pair with its element index.
//   A token shift register, matched to the pipeline latency, carries the tag alongside
//   the pair. The controller then registers pl_lambda together with that tag.
//   The arithmetic belongs to the pipeline; the data passes through this block unmodified.
//
// Optional feature: define LAMBDA_SEQ_PERF_EN to add the perf_cycles / perf_stall counters.
//
// Ports
//   clk, reset           clock (posedge), synchronous active-high reset
//   start                begin a frame (only honoured in idle)
//   busy                 high while issuing or draining
//   done                 one-cycle pulse the cycle after the frame's last result
//   in_valid/in_ready    upstream pair handshake; in_ready depends on state only
//   in_mean/in_var       upstream pair
//   pl_mean/pl_var       pair presented to the pipeline (held between transfers)
//   pl_lambda            pipeline result
//   out_valid/out_idx    tagged result strobe and element index (no backpressure)
//   out_data             registered pl_lambda
//   perf_cycles          [LAMBDA_SEQ_PERF_EN] issue+drain cycles of last completed frame
//   perf_stall           [LAMBDA_SEQ_PERF_EN] issue cycles without in_valid, last frame

module lambda_seq_ctrl #(
   parameter int unsigned BITSIZE  = 20,
   parameter int unsigned N_ELEM   = 16,
   parameter int unsigned PIPE_LAT = 12,
   parameter int unsigned IDX_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BITSIZE-1:0] in_mean,
   input  logic [BITSIZE-1:0] in_var,
   output logic [BITSIZE-1:0] pl_mean,
   output logic [BITSIZE-1:0] pl_var,
   input  logic [BITSIZE-1:0] pl_lambda,
   output logic               out_valid,
   output logic [IDX_W-1:0]   out_idx,
   output logic [BITSIZE-1:0] out_data
`ifdef LAMBDA_SEQ_PERF_EN
   ,
   output logic [31:0]        perf_cycles,
   output logic [15:0]        perf_stall
`endif
);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   issue_cnt_q;
   logic               xfer;
   logic               last_issue;
   logic               last_out;

   // Token shift register: a valid bit plus the element tag per pipeline stage.
   logic [PIPE_LAT-1:0] tok_vld_q;
   logic [IDX_W-1:0]    tok_idx_q [PIPE_LAT];

   logic [BITSIZE-1:0] pl_mean_q, pl_var_q;
   logic               out_valid_q;
   logic [IDX_W-1:0]   out_idx_q;
   logic [BITSIZE-1:0] out_data_q;

   assign in_ready   = (state_q == StIssue);
   assign xfer       = in_valid & in_ready;
   assign last_issue = (issue_cnt_q == IDX_W'(N_ELEM - 1));
   // The frame is finished once the last tag has reached the output register.
   assign last_out   = out_valid_q & (out_idx_q == IDX_W'(N_ELEM - 1));

   assign busy      = (state_q == StIssue) || (state_q == StDrain);
   assign done      = (state_q == StDone);
   assign pl_mean   = pl_mean_q;
   assign pl_var    = pl_var_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_data  = out_data_q;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StIssue;
         StIssue: if (xfer && last_issue) state_d = StDrain;
         StDrain: if (last_out) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ------------------------------------------------------------------
   // Issue counter: cleared on frame start, held at N_ELEM-1 after the last
   // transfer so it never wraps inside a frame.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         issue_cnt_q <= '0;
      end else if ((state_q == StIdle) && start) begin
         issue_cnt_q <= '0;
      end else if (xfer && !last_issue) begin
         issue_cnt_q <= issue_cnt_q + IDX_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Pipeline operand registers: loaded on transfer, held otherwise.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         pl_mean_q <= '0;
         pl_var_q  <= '0;
      end else if (xfer) begin
         pl_mean_q <= in_mean;
         pl_var_q  <= in_var;
      end
   end

   // ------------------------------------------------------------------
   // Token shift register: shifts every cycle, bubbles enter as zero tokens.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         tok_vld_q <= '0;
         for (int i = 0; i < int'(PIPE_LAT); i++) begin
            tok_idx_q[i] <= '0;
         end
      end else begin
         tok_vld_q[0] <= xfer;
         tok_idx_q[0] <= xfer ? issue_cnt_q : '0;
         for (int i = 1; i < int'(PIPE_LAT); i++) begin
            tok_vld_q[i] <= tok_vld_q[i-1];
            tok_idx_q[i] <= tok_idx_q[i-1];
         end
      end
   end

   // ------------------------------------------------------------------
   // Result register: captures pl_lambda with the tag of the exiting token.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= tok_vld_q[PIPE_LAT-1];
         if (tok_vld_q[PIPE_LAT-1]) begin
            out_idx_q  <= tok_idx_q[PIPE_LAT-1];
            out_data_q <= pl_lambda;
         end
      end
   end

`ifdef LAMBDA_SEQ_PERF_EN
   // ------------------------------------------------------------------
   // Performance counters: running counts for the current frame. They are
   // published on the done cycle and saturate at all-ones.
   // ------------------------------------------------------------------
   logic [31:0] cyc_cnt_q, perf_cycles_q;
   logic [15:0] stall_cnt_q, perf_stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt_q     <= '0;
         stall_cnt_q   <= '0;
         perf_cycles_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if ((state_q == StIdle) && start) begin
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
         end else begin
            if (busy && (cyc_cnt_q != '1)) begin
               cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end
            if ((state_q == StIssue) && !in_valid && (stall_cnt_q != '1)) begin
               stall_cnt_q <= stall_cnt_q + 16'd1;
            end
         end
         if (state_q == StDone) begin
            perf_cycles_q <= cyc_cnt_q;
            perf_stall_q  <= stall_cnt_q;
         end
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule
